// File: rtl/ram_2p_pipe.sv
// ram_2p_pipe: parametrised true dual-port RAM with request/grant handshake
// and a 1..4 cycle read pipeline. Used as local SRAM behind bus hosts.
//
// Ports (each port X in {a, b}):
//   clk_i, rst_i     clock, synchronous active-high reset
//   X_req_i          request
//   X_gnt_o          request accepted this cycle (combinational)
//   X_we_i           1 = write, 0 = read
//   X_be_i           byte enables, used by writes only
//   X_addr_i         byte address; word index = addr >> AddrOffsetX
//   X_wdata_i        write data
//   X_rvalid_o       read response valid, ReadLatency cycles after accept
//   X_rerr_o         read response was out of range (qualified by rvalid)
//   X_rdata_o        read data (0 for out-of-range reads)
//
// Optional feature: define RAM_2P_PIPE_FWD_EN to forward a same-cycle write
// on one port to a read of the same word on the other port. Without it the
// reader sees the word as it was before the write (read-first).
//
// Handshake: a request is accepted in a cycle where req=1 and gnt=1, and
// the operation takes effect at the closing clock edge. A requester whose
// gnt is low must keep its request stable until gnt is seen high. Port A
// is always granted outside reset; port B is held off only when both ports
// write the same in-range word in the same cycle. Read responses have no
// backpressure: rvalid pulses for one cycle and rdata/rerr then hold.

module ram_2p_pipe #(
  parameter int unsigned Depth       = 128,
  parameter int unsigned Width       = 32,
  parameter int unsigned AddrOffsetA = 2,
  parameter int unsigned AddrOffsetB = 2,
  parameter int unsigned ReadLatency = 1,
  parameter string       MemInitFile = ""
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               a_req_i,
  output logic               a_gnt_o,
  input  logic               a_we_i,
  input  logic [Width/8-1:0] a_be_i,
  input  logic [31:0]        a_addr_i,
  input  logic [Width-1:0]   a_wdata_i,
  output logic               a_rvalid_o,
  output logic               a_rerr_o,
  output logic [Width-1:0]   a_rdata_o,
  input  logic               b_req_i,
  output logic               b_gnt_o,
  input  logic               b_we_i,
  input  logic [Width/8-1:0] b_be_i,
  input  logic [31:0]        b_addr_i,
  input  logic [Width-1:0]   b_wdata_i,
  output logic               b_rvalid_o,
  output logic               b_rerr_o,
  output logic [Width-1:0]   b_rdata_o
);

  localparam int unsigned NumBytes = Width / 8;
  localparam int unsigned IdxW     = (Depth > 1) ? $clog2(Depth) : 1;

  if (Width % 8 != 0) begin : g_bad_width
    $error("ram_2p_pipe: Width must be a multiple of 8");
  end
  if (ReadLatency < 1 || ReadLatency > 4) begin : g_bad_latency
    $error("ram_2p_pipe: ReadLatency must be 1..4");
  end
  if (Depth < 2) begin : g_bad_depth
    $error("ram_2p_pipe: Depth must be at least 2");
  end

  // Storage array; never reset so contents survive rst_i.
  logic [Width-1:0] mem_q [Depth];

  // Index 0 is port A, index 1 is port B.
  logic [1:0]               req, we, in_range, gnt, wr_en, rd_en;
  logic [1:0][NumBytes-1:0] be;
  logic [1:0][31:0]         idx;
  logic [1:0][Width-1:0]    wdata, rd_word, rdata;
  logic [1:0]               rvalid, rerr;
  logic                     ww_clash;

  always_comb begin
    req      = {b_req_i, a_req_i};
    we       = {b_we_i, a_we_i};
    be[0]    = a_be_i;
    be[1]    = b_be_i;
    wdata[0] = a_wdata_i;
    wdata[1] = b_wdata_i;
    idx[0]   = a_addr_i >> AddrOffsetA;
    idx[1]   = b_addr_i >> AddrOffsetB;
    for (int p = 0; p < 2; p++) begin
      // Full 32-bit compare so nonzero upper address bits count as out of range.
      in_range[p] = idx[p] < Depth;
    end
    ww_clash = req[0] & we[0] & req[1] & we[1] & in_range[0] & in_range[1]
             & (idx[0] == idx[1]);
    gnt[0] = req[0] & ~rst_i;
    gnt[1] = req[1] & ~rst_i & ~ww_clash;
    for (int p = 0; p < 2; p++) begin
      wr_en[p] = gnt[p] & we[p] & in_range[p];
      rd_en[p] = gnt[p] & ~we[p];
    end
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_word[p] = '0;
      if (in_range[p]) begin
        rd_word[p] = mem_q[idx[p][IdxW-1:0]];
      end
    end
`ifdef RAM_2P_PIPE_FWD_EN
    // Merge the other port's same-cycle write into the read word.
    for (int p = 0; p < 2; p++) begin
      if (wr_en[1-p] && in_range[p] && (idx[1-p] == idx[p])) begin
        for (int b = 0; b < NumBytes; b++) begin
          if (be[1-p][b]) begin
            rd_word[p][8*b +: 8] = wdata[1-p][8*b +: 8];
          end
        end
      end
    end
`endif
  end

  // Write/write collisions never reach here: B is not granted in that case.
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < 2; p++) begin
      for (int b = 0; b < NumBytes; b++) begin
        if (wr_en[p] && be[p][b]) begin
          mem_q[idx[p][IdxW-1:0]][8*b +: 8] <= wdata[p][8*b +: 8];
        end
      end
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_rd_pipe
    logic [ReadLatency-1:0]            vld_q, vld_d, err_q, err_d;
    logic [ReadLatency-1:0][Width-1:0] dat_q, dat_d;

    // Data/err stages only load behind a valid entry, so the last stage
    // holds the previous response while rvalid is low.
    always_comb begin
      vld_d    = '0;
      err_d    = err_q;
      dat_d    = dat_q;
      vld_d[0] = rd_en[p];
      if (rd_en[p]) begin
        err_d[0] = ~in_range[p];
        dat_d[0] = rd_word[p];
      end
      for (int s = 1; s < ReadLatency; s++) begin
        vld_d[s] = vld_q[s-1];
        if (vld_q[s-1]) begin
          err_d[s] = err_q[s-1];
          dat_d[s] = dat_q[s-1];
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        vld_q <= '0;
        err_q <= '0;
        dat_q <= '0;
      end else begin
        vld_q <= vld_d;
        err_q <= err_d;
        dat_q <= dat_d;
      end
    end

    assign rvalid[p] = vld_q[ReadLatency-1];
    assign rerr[p]   = err_q[ReadLatency-1];
    assign rdata[p]  = dat_q[ReadLatency-1];
  end

  assign a_gnt_o    = gnt[0];
  assign b_gnt_o    = gnt[1];
  assign a_rvalid_o = rvalid[0];
  assign b_rvalid_o = rvalid[1];
  assign a_rerr_o   = rerr[0];
  assign b_rerr_o   = rerr[1];
  assign a_rdata_o  = rdata[0];
  assign b_rdata_o  = rdata[1];

endmodule

// File: tb/tb_ram_2p_pipe.sv
// Bench for ram_2p_pipe. Two instances share one stimulus stream:
//   inst 0: Depth=128, ReadLatency=1   inst 1: Depth=100, ReadLatency=3
// A bench-side memory model predicts grants and read responses; expected
// responses are queued at accept time and compared when rvalid appears.

module tb_ram_2p_pipe;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // shared stimulus
  logic        a_req, a_we, b_req, b_we;
  logic [3:0]  a_be, b_be;
  logic [31:0] a_addr, b_addr, a_wdata, b_wdata;

  // outputs, k = inst*2 + port
  logic [3:0]  gnt, rvalid, rerr;
  logic [31:0] rdata [4];

  ram_2p_pipe #(.Depth(128), .Width(32), .AddrOffsetA(2), .AddrOffsetB(2),
                .ReadLatency(1), .MemInitFile("")) u_dut_l1 (
    .clk_i(clk), .rst_i(rst),
    .a_req_i(a_req), .a_gnt_o(gnt[0]), .a_we_i(a_we), .a_be_i(a_be),
    .a_addr_i(a_addr), .a_wdata_i(a_wdata), .a_rvalid_o(rvalid[0]),
    .a_rerr_o(rerr[0]), .a_rdata_o(rdata[0]),
    .b_req_i(b_req), .b_gnt_o(gnt[1]), .b_we_i(b_we), .b_be_i(b_be),
    .b_addr_i(b_addr), .b_wdata_i(b_wdata), .b_rvalid_o(rvalid[1]),
    .b_rerr_o(rerr[1]), .b_rdata_o(rdata[1])
  );

  ram_2p_pipe #(.Depth(100), .Width(32), .AddrOffsetA(2), .AddrOffsetB(2),
                .ReadLatency(3), .MemInitFile("")) u_dut_l3 (
    .clk_i(clk), .rst_i(rst),
    .a_req_i(a_req), .a_gnt_o(gnt[2]), .a_we_i(a_we), .a_be_i(a_be),
    .a_addr_i(a_addr), .a_wdata_i(a_wdata), .a_rvalid_o(rvalid[2]),
    .a_rerr_o(rerr[2]), .a_rdata_o(rdata[2]),
    .b_req_i(b_req), .b_gnt_o(gnt[3]), .b_we_i(b_we), .b_be_i(b_be),
    .b_addr_i(b_addr), .b_wdata_i(b_wdata), .b_rvalid_o(rvalid[3]),
    .b_rerr_o(rerr[3]), .b_rdata_o(rdata[3])
  );

  // scoreboard: entry = {due_cycle[15:0], err, data[31:0]}
  logic [48:0] exp_q [4][$];
  logic [31:0] mdl [2][128];
  int          depth_c [2] = '{128, 100};
  int          lat_c   [2] = '{1, 3};
  logic [31:0] last_d [4];
  logic        last_e [4];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        rst_edge = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w,
                                        input logic [31:0] new_w,
                                        input logic [3:0]  be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  task automatic check_outputs();
    logic [48:0] e;
    for (int k = 0; k < 4; k++) begin
      if (rst_edge) begin
        exp_q[k].delete();
        last_d[k] = '0;
        last_e[k] = 1'b0;
        chk($sformatf("rst_rvalid[%0d]", k), 64'(rvalid[k]), 64'(1'b0));
        chk($sformatf("rst_rerr[%0d]", k), 64'(rerr[k]), 64'(1'b0));
        chk($sformatf("rst_rdata[%0d]", k), 64'(rdata[k]), 64'(32'h0));
      end else if (rvalid[k]) begin
        if (exp_q[k].size() == 0) begin
          chk($sformatf("unexpected_rvalid[%0d]", k), 64'(rvalid[k]), 64'(1'b0));
        end else begin
          e = exp_q[k].pop_front();
          chk($sformatf("latency_cycle[%0d]", k), 64'(16'(cyc)), 64'(e[48:33]));
          chk($sformatf("rerr[%0d]", k), 64'(rerr[k]), 64'(e[32]));
          chk($sformatf("rdata[%0d]", k), 64'(rdata[k]), 64'(e[31:0]));
        end
        last_d[k] = rdata[k];
        last_e[k] = rerr[k];
      end else begin
        chk($sformatf("hold_rdata[%0d]", k), 64'(rdata[k]), 64'(last_d[k]));
        chk($sformatf("hold_rerr[%0d]", k), 64'(rerr[k]), 64'(last_e[k]));
        if (exp_q[k].size() > 0) begin
          e = exp_q[k][0];
          if (int'(e[48:33]) <= cyc) begin
            chk($sformatf("missing_rvalid[%0d]", k), 64'(rvalid[k]), 64'(1'b1));
            void'(exp_q[k].pop_front());
          end
        end
      end
    end
  endtask

  task automatic model_cycle();
    logic [31:0] ia, ib, w;
    logic        ina, inb, ga, gb;
    for (int i = 0; i < 2; i++) begin
      ia  = a_addr >> 2;
      ib  = b_addr >> 2;
      ina = ia < 32'(depth_c[i]);
      inb = ib < 32'(depth_c[i]);
      ga  = a_req & ~rst;
      gb  = b_req & ~rst & ~(a_req & a_we & b_we & ina & inb & (ia == ib));
      chk($sformatf("a_gnt[inst%0d]", i), 64'(gnt[2*i]), 64'(ga));
      chk($sformatf("b_gnt[inst%0d]", i), 64'(gnt[2*i+1]), 64'(gb));
      if (ga && !a_we) begin
        w = ina ? mdl[i][ia[6:0]] : 32'h0;
`ifdef RAM_2P_PIPE_FWD_EN
        if (gb && b_we && inb && ina && ia == ib) w = merge(w, b_wdata, b_be);
`endif
        exp_q[2*i].push_back({16'(cyc + lat_c[i]), ~ina, w});
      end
      if (gb && !b_we) begin
        w = inb ? mdl[i][ib[6:0]] : 32'h0;
`ifdef RAM_2P_PIPE_FWD_EN
        if (ga && a_we && ina && inb && ia == ib) w = merge(w, a_wdata, a_be);
`endif
        exp_q[2*i+1].push_back({16'(cyc + lat_c[i]), ~inb, w});
      end
      if (ga && a_we && ina) mdl[i][ia[6:0]] = merge(mdl[i][ia[6:0]], a_wdata, a_be);
      if (gb && b_we && inb) mdl[i][ib[6:0]] = merge(mdl[i][ib[6:0]], b_wdata, b_be);
    end
  endtask

  // one clock cycle with the inputs currently driven
  task automatic step();
    @(negedge clk);
    if (cyc > 0) check_outputs();
    model_cycle();
    @(posedge clk);
    cyc++;
    rst_edge = rst;
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // driver tasks
  task automatic drv_a(input logic req, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata);
    a_req = req; a_we = we; a_be = be; a_addr = addr; a_wdata = wdata;
  endtask

  task automatic drv_b(input logic req, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata);
    b_req = req; b_we = we; b_be = be; b_addr = addr; b_wdata = wdata;
  endtask

  task automatic idle();
    drv_a(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drv_b(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    // reset with a pending request: gnt must stay low
    rst = 1'b1;
    idle();
    drv_a(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    run(2);
    rst = 1'b0;
    idle();
    step();

    // write then read back
    drv_a(1'b1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF); step();
    drv_a(1'b1, 1'b0, 4'hF, 32'h10, 32'h0);        step();
    idle(); run(4);

    // byte mask
    drv_a(1'b1, 1'b1, 4'hF, 32'h20, 32'h11223344); step();
    idle();
    drv_b(1'b1, 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD); step();
    drv_b(1'b1, 1'b0, 4'h0, 32'h20, 32'h0); step();
    idle(); run(4);

    // write/write collision: B held for a cycle
    drv_a(1'b1, 1'b1, 4'hF, 32'h30, 32'h1);
    drv_b(1'b1, 1'b1, 4'hF, 32'h30, 32'h2); step();
    drv_a(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);  step();
    idle();
    drv_b(1'b1, 1'b0, 4'h0, 32'h30, 32'h0); step();
    idle(); run(4);

    // read/write collision, full and partial byte enables, both directions
    drv_a(1'b1, 1'b1, 4'hF, 32'h40, 32'h5); step();
    drv_a(1'b1, 1'b1, 4'hF, 32'h40, 32'h9);
    drv_b(1'b1, 1'b0, 4'h0, 32'h40, 32'h0); step();
    drv_a(1'b1, 1'b1, 4'b0011, 32'h40, 32'hFFFFFFFF); step();
    idle();
    drv_b(1'b1, 1'b0, 4'h0, 32'h40, 32'h0); step();
    drv_a(1'b1, 1'b1, 4'hF, 32'h44, 32'h12345678); idle(); step();
    drv_b(1'b1, 1'b1, 4'b1100, 32'h44, 32'hCAFEF00D);
    drv_a(1'b1, 1'b0, 4'h0, 32'h44, 32'h0); step();
    idle();
    drv_a(1'b1, 1'b0, 4'h0, 32'h44, 32'h0); step();
    idle(); run(4);

    // depth boundary, out-of-range writes and upper address bits
    drv_a(1'b1, 1'b1, 4'hF, 32'h0, 32'hA0A0A0A0);     step();
    drv_a(1'b1, 1'b1, 4'hF, 32'h188, 32'h98);         step();
    drv_a(1'b1, 1'b1, 4'hF, 32'h18C, 32'h99);         step();
    drv_a(1'b1, 1'b1, 4'hF, 32'h190, 32'h100100);     step();
    drv_a(1'b1, 1'b1, 4'hF, 32'h80000010, 32'hBAD);   step();
    drv_a(1'b1, 1'b0, 4'h0, 32'h188, 32'h0);
    drv_b(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);            step();
    drv_a(1'b1, 1'b0, 4'h0, 32'h18C, 32'h0);
    drv_b(1'b1, 1'b0, 4'h0, 32'h13, 32'h0);           step();
    drv_a(1'b1, 1'b0, 4'h0, 32'h190, 32'h0);
    drv_b(1'b1, 1'b0, 4'h0, 32'h80000010, 32'h0);     step();
    // both write idx 100: collision only where it is in range
    drv_a(1'b1, 1'b1, 4'hF, 32'h190, 32'h55);
    drv_b(1'b1, 1'b1, 4'hF, 32'h190, 32'h66);         step();
    idle();
    drv_b(1'b1, 1'b0, 4'h0, 32'h190, 32'h0);          step();
    idle(); run(4);

    // constrained random traffic over 16 pre-written words
    for (int i = 0; i < 16; i++) begin
      drv_a(1'b1, 1'b1, 4'hF, 32'(i * 4), $urandom());
      step();
    end
    for (int n = 0; n < 60; n++) begin
      drv_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)),
            32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3)), $urandom());
      drv_b(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)),
            32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3)), $urandom());
      step();
    end
    idle(); run(4);

    // reset mid-operation: in-flight reads discarded, contents persist
    drv_a(1'b1, 1'b0, 4'h0, 32'h10, 32'h0); step();
    drv_a(1'b1, 1'b0, 4'h0, 32'h20, 32'h0); step();
    rst = 1'b1;
    drv_a(1'b1, 1'b0, 4'h0, 32'h10, 32'h0); step();
    rst = 1'b0;
    idle(); run(5);
    drv_a(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    drv_b(1'b1, 1'b0, 4'h0, 32'h20, 32'h0); step();
    idle(); run(5);

    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drained_q[%0d]", k), 64'(exp_q[k].size()), 64'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    if (errors == 0) $display("TEST PASSED");
    else             $display("TEST FAILED");
    $finish;
  end

endmodule
